// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP inference pipeline: widths, loader states
// and the pixel-to-neuron fixed-point conversion.
package mlp_pkg;

  localparam int unsigned NEURON_ADDR_W = 12;
  localparam int unsigned NEURON_DATA_W = 16;
  localparam int unsigned PIXEL_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    KICK = 2'd2,
    BUSY = 2'd3
  } loader_state_t;

  // Unsigned pixel, zero-extended then scaled; a shift of at most 7 keeps it positive.
  function automatic logic [NEURON_DATA_W-1:0] pixel_to_q(
    input logic [PIXEL_W-1:0] pixel,
    input int unsigned        shift
  );
    logic [NEURON_DATA_W-1:0] ext;
    ext = {{(NEURON_DATA_W-PIXEL_W){1'b0}}, pixel};
    return ext << shift;
  endfunction

endpackage

// File: rtl/input_loader.sv
// Streams one pixel frame into layer-0 neuron memory, then launches inference
// and blocks further input until the control unit reports completion.
module input_loader
  import mlp_pkg::*;
#(
  parameter int unsigned N_INPUTS   = 784,
  parameter int unsigned ADDR_W     = NEURON_ADDR_W,
  parameter int unsigned DATA_W     = NEURON_DATA_W,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_data,
  input  logic               in_last,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               start,
  input  logic               infer_done,
  output logic               frame_err,
  output logic [7:0]         frame_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  loader_state_t     r_state;
  loader_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_accept;
  logic              w_err_set;
  logic              w_start_nxt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_start;
  logic              r_frame_err;
  logic [7:0]        r_frame_count;

  // Ready is gated by reset so the upstream sees no acceptance while held in reset.
  assign in_ready = reset & ((r_state == IDLE) | (r_state == LOAD));
  assign w_accept = in_valid & in_ready;

  // Next-state, beat counter and event decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    w_start_nxt = 1'b0;
    case (r_state)
      IDLE, LOAD: begin
        if (w_accept) begin
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = KICK;
            w_cnt_nxt   = {ADDR_W{1'b0}};
            w_err_set   = ~in_last;
          end else if (in_last) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {ADDR_W{1'b0}};
            w_err_set   = 1'b1;
          end else begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = r_cnt + ADDR_W'(1);
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      KICK: begin
        w_state_nxt = BUSY;
        w_start_nxt = 1'b1;
      end
      BUSY: begin
        if (infer_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered memory write port, start pulse and frame status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en       <= 1'b0;
      r_wr_addr     <= {ADDR_W{1'b0}};
      r_wr_data     <= {DATA_W{1'b0}};
      r_start       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_wr_en     <= w_accept;
      r_start     <= w_start_nxt;
      r_frame_err <= r_frame_err | w_err_set;
      if (w_accept) begin
        r_wr_addr <= BASE + r_cnt;
        r_wr_data <= DATA_W'(pixel_to_q(in_data, FRAC_SHIFT));
      end else begin
        r_wr_addr <= r_wr_addr;
        r_wr_data <= r_wr_data;
      end
      if (w_start_nxt) begin
        r_frame_count <= r_frame_count + 8'd1;
      end else begin
        r_frame_count <= r_frame_count;
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign start       = r_start;
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_input_loader.sv
// Self-checking bench for input_loader: directed frames plus a randomized
// bubble/wrap run, all checked cycle by cycle against a frame-level model.
module tb_input_loader;
  import mlp_pkg::*;

  localparam int N    = 4;
  localparam int FS   = 2;
  localparam int BASE = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        infer_done;
  logic        frame_err;
  logic [7:0]  frame_count;

  input_loader #(
    .N_INPUTS(N), .ADDR_W(12), .DATA_W(16), .BASE_ADDR(BASE), .FRAC_SHIFT(FS)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .infer_done(infer_done),
    .frame_err(frame_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model: accepting (with next pixel index), awaiting launch, or running.
  int m_phase;
  int m_idx;
  int m_frames;
  int m_frames_total;
  int m_err;
  int m_start;
  int e_wr;
  int e_addr;
  int e_data;
  int starts_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_frames = 0; m_err = 0; m_start = 0;
    e_wr = 0; e_addr = 0; e_data = 0; starts_seen = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; infer_done = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {20'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    check("rst_start", {31'd0, start}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_count", {24'd0, frame_count}, 32'd0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic dn);
    bit acc;
    in_valid = v; in_data = d; in_last = l; infer_done = dn;
    acc = v && (m_phase == 0);
    e_wr = acc ? 1 : 0;
    m_start = 0;
    if (acc) begin
      e_addr = BASE + m_idx;
      e_data = int'(d) * (1 << FS);
      if (m_idx == N - 1) begin
        if (!l) m_err = 1;
        m_phase = 1;
        m_idx = 0;
      end else if (l) begin
        m_err = 1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end else if (m_phase == 1) begin
      m_start = 1;
      m_frames = (m_frames + 1) % 256;
      m_frames_total++;
      m_phase = 2;
    end else if (m_phase == 2 && dn) begin
      m_phase = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, (m_phase == 0) ? 32'd1 : 32'd0);
    check("wr_en", {31'd0, wr_en}, 32'(e_wr));
    if (e_wr != 0) begin
      check("wr_addr", {20'd0, wr_addr}, 32'(e_addr));
      check("wr_data", {16'd0, wr_data}, 32'(e_data));
    end
    check("start", {31'd0, start}, 32'(m_start));
    check("frame_err", {31'd0, frame_err}, 32'(m_err));
    check("frame_count", {24'd0, frame_count}, 32'(m_frames));
    if (start) starts_seen++;
  endtask

  initial begin
    int since;
    logic v;
    m_frames_total = 0;
    model_reset();
    do_reset();

    // Full frame: 1, 2, 255, 0 then launch.
    step(1'b1, 8'd1, 1'b0, 1'b0);
    step(1'b1, 8'd2, 1'b0, 1'b0);
    step(1'b1, 8'd255, 1'b0, 1'b0);
    check("full_wr_data_255", {16'd0, wr_data}, 32'd1020);
    step(1'b1, 8'd0, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("full_start", {31'd0, start}, 32'd1);
    check("full_frame_count", {24'd0, frame_count}, 32'd1);
    check("full_frame_err", {31'd0, frame_err}, 32'd0);

    // Backpressure while busy, then release via infer_done.
    for (int i = 0; i < 10; i++) step(1'b1, 8'd7, 1'b0, 1'b0);
    step(1'b1, 8'd7, 1'b0, 1'b1);
    check("bp_ready_after_done", {31'd0, in_ready}, 32'd1);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    check("bp_addr", {20'd0, wr_addr}, 32'd0);
    check("bp_data", {16'd0, wr_data}, 32'd28);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), (i == 2) ? 1'b1 : 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    check("bp_frame_count", {24'd0, frame_count}, 32'd2);

    // Short frame: last on beat 1, then a frame restarting at address 0.
    do_reset();
    step(1'b1, 8'd10, 1'b0, 1'b0);
    step(1'b1, 8'd11, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("short_err", {31'd0, frame_err}, 32'd1);
    check("short_count", {24'd0, frame_count}, 32'd0);
    check("short_no_start", 32'(starts_seen), 32'd0);
    step(1'b1, 8'd12, 1'b0, 1'b0);
    check("short_restart_addr", {20'd0, wr_addr}, 32'd0);
    for (int i = 1; i < N; i++) step(1'b1, 8'($urandom), (i == N - 1) ? 1'b1 : 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Missing last: start still issued, error flagged.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    check("nolast_start", {31'd0, start}, 32'd1);
    check("nolast_err", {31'd0, frame_err}, 32'd1);
    step(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-frame after two beats, then a clean frame.
    do_reset();
    step(1'b1, 8'd3, 1'b0, 1'b0);
    step(1'b1, 8'd4, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      step(1'b1, 8'(i + 40), (i == N - 1) ? 1'b1 : 1'b0, 1'b0);
      check("rst_mid_addr", {20'd0, wr_addr}, 32'(BASE + i));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
    check("rst_mid_starts", 32'(starts_seen), 32'd1);
    check("rst_mid_count", {24'd0, frame_count}, 32'd1);

    // 256 frames with random bubbles; infer_done five cycles after each start.
    do_reset();
    m_frames_total = 0;
    since = -1;
    for (int cyc = 0; cyc < 20000 && m_frames_total < 256; cyc++) begin
      if (since >= 0) since++;
      v = ($urandom_range(0, 3) != 0);
      step(v, 8'($urandom), (m_idx == N - 1) ? 1'b1 : 1'b0, (since == 5) ? 1'b1 : 1'b0);
      if (since == 5) since = -1;
      if (m_start != 0) since = 0;
    end
    check("wrap_frames_done", 32'(m_frames_total), 32'd256);
    check("wrap_frame_count", {24'd0, frame_count}, 32'd0);
    check("wrap_starts", 32'(starts_seen), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_loader.md
Name: input_loader

Overview:
- Upstream stage of the MLP inference pipeline. It accepts one input frame of 8-bit unsigned pixels over a valid/ready stream and converts each pixel to the 16-bit signed fixed-point neuron format.
- Each converted value is written into the layer-0 region of neuron memory through the memory's write port.
- After the last write it pulses start to the control unit. It then blocks new input until the control unit reports the inference done.

Parameters:
- N_INPUTS, 784, pixels per frame (1..4095)
- ADDR_W, 12, neuron memory address width
- DATA_W, 16, neuron value width
- BASE_ADDR, 0, neuron address of pixel 0
- FRAC_SHIFT, 0, left shift applied to the pixel (0..7)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  loader can accept a beat
- in_data  in  8  unsigned pixel
- in_last  in  1  marks the final beat of the frame
- wr_en  out  1  neuron memory write enable
- wr_addr  out  ADDR_W  neuron memory write address
- wr_data  out  DATA_W  signed neuron value
- start  out  1  one-cycle pulse to the control unit
- infer_done  in  1  done pulse from the control unit
- frame_err  out  1  sticky framing error
- frame_count  out  8  frames launched, wraps modulo 256

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, beat counter=0.
  - wr_en=0, wr_addr=0, wr_data=0, start=0, frame_err=0, frame_count=0, in_ready=0.
  - A reset in any state aborts the partial frame. No start is issued.
- Handshake: a beat is accepted on a clock edge where in_valid=1 and in_ready=1. in_ready is a combinational decode of state: 1 in IDLE and LOAD, 0 otherwise.
- Conversion: wr_data = zero-extend(in_data) << FRAC_SHIFT. The value is never negative and always fits in DATA_W.
- Write timing:
  - For a beat accepted at edge t, wr_en=1 with wr_addr=BASE_ADDR+index and wr_data=converted value, all registered, in the cycle following t.
  - wr_en=0 whenever no beat was accepted. Only one write per beat.
- States:
  - IDLE: the counter holds 0. Accepting a beat writes index 0. Then go to LOAD, or to KICK if N_INPUTS=1.
  - LOAD: each accepted beat writes the current index and increments the counter.
    - When the beat with index N_INPUTS-1 is accepted, go to KICK.
    - If that beat has in_last=0, set frame_err but still go to KICK.
    - If in_last=1 on a beat with index < N_INPUTS-1 (short frame): write that beat, set frame_err, return to IDLE, issue no start, and leave frame_count unchanged.
  - KICK: lasts exactly one cycle; in_ready=0. Go to BUSY. start is registered so that it is high for exactly the first BUSY cycle, i.e. one cycle after the last wr_en. frame_count increments on the same edge.
  - BUSY: in_ready=0. If infer_done=1, go to IDLE on the next edge.
- infer_done handling:
  - infer_done in IDLE, LOAD or KICK is ignored.
  - infer_done in the first BUSY cycle, i.e. simultaneous with start, is honoured.
- in_valid held while in_ready=0: the beat is not consumed and in_data may change freely.
- Counter wrap: the beat counter resets to 0 on every return to IDLE and never exceeds N_INPUTS-1.
- frame_err is sticky until reset.

Decomposition:
- Shared package (mlp_pkg):
  - loader state enum {IDLE, LOAD, KICK, BUSY}
  - NEURON_ADDR_W=12, NEURON_DATA_W=16 (also used by neuron memory and the control unit)
  - PIXEL_W=8
- No sub-module is needed. The pixel-to-fixed-point conversion is one function in the package (pixel_to_q) so the bench reuses it.

Test Plan:
- Full frame:
  - Stimulus: N_INPUTS=4, FRAC_SHIFT=2, pixels 1, 2, 255, 0 on back-to-back beats with in_last on beat 3.
  - Response: writes (0,4), (1,8), (2,1020), (3,0) on consecutive cycles. start high exactly one cycle after the last write. frame_count=1, frame_err=0.
- Backpressure:
  - Stimulus: after start, hold in_valid=1 with pixel 7 for 10 cycles, then pulse infer_done.
  - Response: in_ready=0 and no wr_en throughout. One cycle after infer_done, in_ready=1. The held beat is written to address 0 with value 28.
- Short frame:
  - Stimulus: N_INPUTS=4, in_last on beat 1.
  - Response: two writes (addresses 0, 1), no start, frame_err=1, frame_count unchanged. The next frame restarts at address 0.
- Missing last:
  - Stimulus: 4 beats with in_last=0 throughout.
  - Response: 4 writes, start pulse issued, frame_err=1.
- Reset mid-frame:
  - Stimulus: drop reset after 2 accepted beats, release, send a full frame.
  - Response: all outputs 0 during reset, including in_ready. The following frame writes addresses 0..3, with exactly one start and frame_count=1.
- Bubbles and wrap:
  - Stimulus: 256 frames with random in_valid gaps and infer_done 5 cycles after each start.
  - Response: wr_addr always equals BASE_ADDR+index with no duplicates. frame_count wraps to 0.
